// File: rtl/isqrt_arbiter.sv
// isqrt_arbiter: round-robin sharing of one pipelined isqrt unit among
// N_CLIENTS requesters, with an in-order tag FIFO that routes each result
// back to the client that issued its operand.
module isqrt_arbiter #(
    parameter int unsigned N_CLIENTS    = 2,
    parameter int unsigned MAX_INFLIGHT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CLIENTS-1:0]      req_vld,
    input  logic [N_CLIENTS*32-1:0]   req_x,
    output logic [N_CLIENTS-1:0]      req_rdy,
    output logic [N_CLIENTS-1:0]      rsp_vld,
    output logic [15:0]               rsp_y,
    output logic                      isqrt_x_vld,
    output logic [31:0]               isqrt_x,
    input  logic                      isqrt_y_vld,
    input  logic [15:0]               isqrt_y,
    output logic                      err_orphan
);

    localparam int unsigned TAG_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int unsigned SUM_W = TAG_W + 1;
    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] tag_mem [MAX_INFLIGHT];

    logic             grant_vld;
    logic [TAG_W-1:0] grant_idx;
    logic [SUM_W-1:0] scan_sum;
    logic [SUM_W-1:0] rr_sum;
    logic [TAG_W-1:0] rr_next;
    logic             fifo_full;
    logic             grant_ok;
    logic             pop;
    logic             orphan;
    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] count_next;

    // Round-robin search: first requester at or after rr_ptr, wrapping modulo N_CLIENTS
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = 0; k < int'(N_CLIENTS); k++) begin
            scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (scan_sum >= SUM_W'(N_CLIENTS)) begin
                scan_sum = scan_sum - SUM_W'(N_CLIENTS);
            end
            if (!grant_vld && req_vld[TAG_W'(scan_sum)]) begin
                grant_vld = 1'b1;
                grant_idx = TAG_W'(scan_sum);
            end
        end
    end

    // Grant, issue and occupancy decode; a full FIFO blocks issue even when a pop coincides
    always_comb begin
        fifo_full   = (count == CNT_W'(MAX_INFLIGHT));
        grant_ok    = grant_vld && !fifo_full && !rst;
        req_rdy     = grant_ok ? (N_CLIENTS'(1) << grant_idx) : '0;
        isqrt_x_vld = grant_ok;
        isqrt_x     = '0;
        for (int i = 0; i < int'(N_CLIENTS); i++) begin
            if (req_rdy[i]) begin
                isqrt_x = req_x[32*i +: 32];
            end
        end

        rr_sum = {1'b0, grant_idx} + SUM_W'(1);
        if (rr_sum >= SUM_W'(N_CLIENTS)) begin
            rr_sum = rr_sum - SUM_W'(N_CLIENTS);
        end
        rr_next = TAG_W'(rr_sum);

        pop      = isqrt_y_vld && (count != '0);
        orphan   = isqrt_y_vld && (count == '0);
        head_tag = tag_mem[rd_ptr];

        count_next = count;
        if (isqrt_x_vld && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!isqrt_x_vld && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Control state, result routing and the sticky orphan flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rsp_vld    <= '0;
            rsp_y      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (isqrt_x_vld) begin
                rr_ptr <= rr_next;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rsp_y  <= isqrt_y;
            end
            count   <= count_next;
            rsp_vld <= pop ? (N_CLIENTS'(1) << head_tag) : '0;
            if (orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage: owner of each issued operation, in issue order
    always_ff @(posedge clk) begin
        if (isqrt_x_vld) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter: two instances (2 clients / 16 deep with a
// latency-4 isqrt stand-in, 4 clients / 4 deep with a latency-8 stand-in).
module tb_isqrt_arbiter;

    localparam int unsigned L_A = 4;
    localparam int unsigned L_B = 8;

    logic clk;
    logic rst;

    int errors;
    int checks;

    // Instance A: 2 clients, 16 in flight
    logic [1:0]   a_req_vld;
    logic [63:0]  a_req_x;
    logic [1:0]   a_req_rdy;
    logic [1:0]   a_rsp_vld;
    logic [15:0]  a_rsp_y;
    logic         a_x_vld;
    logic [31:0]  a_x;
    logic         a_y_vld;
    logic [15:0]  a_y;
    logic         a_err;
    logic         a_force;

    // Instance B: 4 clients, 4 in flight
    logic [3:0]   b_req_vld;
    logic [127:0] b_req_x;
    logic [3:0]   b_req_rdy;
    logic [3:0]   b_rsp_vld;
    logic [15:0]  b_rsp_y;
    logic         b_x_vld;
    logic [31:0]  b_x;
    logic         b_y_vld;
    logic [15:0]  b_y;
    logic         b_err;

    isqrt_arbiter #(.N_CLIENTS(2), .MAX_INFLIGHT(16)) dut_a (
        .clk(clk), .rst(rst),
        .req_vld(a_req_vld), .req_x(a_req_x), .req_rdy(a_req_rdy),
        .rsp_vld(a_rsp_vld), .rsp_y(a_rsp_y),
        .isqrt_x_vld(a_x_vld), .isqrt_x(a_x),
        .isqrt_y_vld(a_y_vld), .isqrt_y(a_y),
        .err_orphan(a_err)
    );

    isqrt_arbiter #(.N_CLIENTS(4), .MAX_INFLIGHT(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_vld(b_req_vld), .req_x(b_req_x), .req_rdy(b_req_rdy),
        .rsp_vld(b_rsp_vld), .rsp_y(b_rsp_y),
        .isqrt_x_vld(b_x_vld), .isqrt_x(b_x),
        .isqrt_y_vld(b_y_vld), .isqrt_y(b_y),
        .err_orphan(b_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] isqrt_f(input logic [31:0] x);
        longint unsigned r;
        r = 0;
        while (((r + 1) * (r + 1) <= longint'(x)) && (r < 65535)) r++;
        return 16'(r);
    endfunction

    // isqrt stand-ins: result valid L edges after the operand edge, reset by rst
    logic        a_pv [0:L_A];
    logic [15:0] a_py [0:L_A];
    logic        b_pv [0:L_B];
    logic [15:0] b_py [0:L_B];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= int'(L_A); k++) begin a_pv[k] <= 1'b0; a_py[k] <= '0; end
            for (int k = 0; k <= int'(L_B); k++) begin b_pv[k] <= 1'b0; b_py[k] <= '0; end
        end else begin
            a_pv[0] <= a_x_vld;
            a_py[0] <= isqrt_f(a_x);
            for (int k = 1; k <= int'(L_A); k++) begin a_pv[k] <= a_pv[k-1]; a_py[k] <= a_py[k-1]; end
            b_pv[0] <= b_x_vld;
            b_py[0] <= isqrt_f(b_x);
            for (int k = 1; k <= int'(L_B); k++) begin b_pv[k] <= b_pv[k-1]; b_py[k] <= b_py[k-1]; end
        end
    end

    assign a_y_vld = a_pv[L_A] | a_force;
    assign a_y     = a_py[L_A];
    assign b_y_vld = b_pv[L_B];
    assign b_y     = b_py[L_B];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_req_vld = '0; b_req_vld = '0; a_force = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        a_req_vld = 2'b11;
        b_req_vld = 4'b1111;
        a_req_x = {32'd81, 32'd16};
        b_req_x = '0;
        a_force = 1'b0;
        #1;
        checks++;
        if (a_req_rdy !== 2'b00) begin errors++; $display("FAIL reset_a_rdy: got %b want 00", a_req_rdy); end
        checks++;
        if (b_req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_b_rdy: got %b want 0000", b_req_rdy); end
        checks++;
        if (a_x_vld !== 1'b0) begin errors++; $display("FAIL reset_a_xvld: got %b want 0", a_x_vld); end
        @(negedge clk);
        #1;
        checks++;
        if (a_rsp_vld !== 2'b00 || a_rsp_y !== 16'd0 || a_err !== 1'b0) begin
            errors++; $display("FAIL reset_a_regs: rsp_vld=%b rsp_y=%0d err=%b want 00/0/0", a_rsp_vld, a_rsp_y, a_err);
        end
        checks++;
        if (b_rsp_vld !== 4'b0000 || b_rsp_y !== 16'd0 || b_err !== 1'b0) begin
            errors++; $display("FAIL reset_b_regs: rsp_vld=%b rsp_y=%0d err=%b want 0000/0/0", b_rsp_vld, b_rsp_y, b_err);
        end
        rst = 1'b0;
        a_req_vld = '0;
        b_req_vld = '0;
    endtask

    task automatic test_single();
        logic [1:0] exp_v;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_req_vld = (c == 0) ? 2'b01 : 2'b00;
            a_req_x = {32'd0, 32'd144};
            #1;
            if (c == 0) begin
                checks++;
                if (a_req_rdy !== 2'b01 || a_x_vld !== 1'b1 || a_x !== 32'd144) begin
                    errors++; $display("FAIL single_issue: rdy=%b xvld=%b x=%0d want 01/1/144", a_req_rdy, a_x_vld, a_x);
                end
            end
            exp_v = (c == 6) ? 2'b01 : 2'b00;
            checks++;
            if (a_rsp_vld !== exp_v) begin
                errors++; $display("FAIL single_rsp_vld c=%0d: got %b want %b", c, a_rsp_vld, exp_v);
            end
            if (c == 6) begin
                checks++;
                if (a_rsp_y !== 16'd12) begin errors++; $display("FAIL single_rsp_y: got %0d want 12", a_rsp_y); end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_x;
        logic [1:0]  exp_v;
        logic [15:0] exp_y;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            a_req_vld = (c < 12) ? 2'b11 : 2'b00;
            a_req_x = {32'd81, 32'd16};
            #1;
            if (c < 12) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                exp_x   = (c % 2 == 0) ? 32'd16 : 32'd81;
                checks++;
                if (a_req_rdy !== exp_rdy || a_x_vld !== 1'b1 || a_x !== exp_x) begin
                    errors++; $display("FAIL contention_grant c=%0d: rdy=%b x=%0d want %b/%0d", c, a_req_rdy, a_x, exp_rdy, exp_x);
                end
            end
            exp_v = (c < 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            exp_y = (c % 2 == 0) ? 16'd4 : 16'd9;
            checks++;
            if (a_rsp_vld !== exp_v) begin
                errors++; $display("FAIL contention_rsp_vld c=%0d: got %b want %b", c, a_rsp_vld, exp_v);
            end
            if (c >= 6) begin
                checks++;
                if (a_rsp_y !== exp_y) begin errors++; $display("FAIL contention_rsp_y c=%0d: got %0d want %0d", c, a_rsp_y, exp_y); end
            end
        end
    endtask

    task automatic test_full_fifo();
        logic exp_r;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            b_req_vld = 4'b0001;
            b_req_x = {96'd0, 32'd25};
            #1;
            exp_r = (c <= 3) || (c >= 10 && c <= 13) || (c == 20);
            checks++;
            if (b_req_rdy[0] !== exp_r || b_req_rdy[3:1] !== 3'b000) begin
                errors++; $display("FAIL full_rdy c=%0d: got %b want %b", c, b_req_rdy, {3'b000, exp_r});
            end
            if (c == 10) begin
                checks++;
                if (b_rsp_vld !== 4'b0001 || b_rsp_y !== 16'd5) begin
                    errors++; $display("FAIL full_first_rsp: rsp_vld=%b y=%0d want 0001/5", b_rsp_vld, b_rsp_y);
                end
            end
        end
        b_req_vld = '0;
    endtask

    task automatic test_rr_wrap();
        logic [3:0]  vld_tab [0:3];
        logic [3:0]  rdy_tab [0:3];
        logic [31:0] x_tab   [0:3];
        vld_tab = '{4'b0001, 4'b1001, 4'b1001, 4'b1001};
        rdy_tab = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
        x_tab   = '{32'd4, 32'd9, 32'd4, 32'd9};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            b_req_vld = vld_tab[c];
            b_req_x = {32'd9, 32'd0, 32'd0, 32'd4};
            #1;
            checks++;
            if (b_req_rdy !== rdy_tab[c] || b_x !== x_tab[c]) begin
                errors++; $display("FAIL rr_wrap c=%0d: rdy=%b x=%0d want %b/%0d", c, b_req_rdy, b_x, rdy_tab[c], x_tab[c]);
            end
        end
        @(negedge clk);
        b_req_vld = '0;
    endtask

    task automatic test_orphan();
        logic [1:0] exp_v;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            a_force = (c == 0);
            a_req_vld = (c == 6) ? 2'b01 : 2'b00;
            a_req_x = {32'd0, 32'd144};
            #1;
            checks++;
            if (a_err !== ((c == 0) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL orphan_flag c=%0d: got %b want %b", c, a_err, (c != 0));
            end
            if (c == 6) begin
                checks++;
                if (a_req_rdy !== 2'b01) begin errors++; $display("FAIL orphan_rdy: got %b want 01", a_req_rdy); end
            end
            exp_v = (c == 12) ? 2'b01 : 2'b00;
            checks++;
            if (a_rsp_vld !== exp_v) begin
                errors++; $display("FAIL orphan_rsp_vld c=%0d: got %b want %b", c, a_rsp_vld, exp_v);
            end
            if (c == 12) begin
                checks++;
                if (a_rsp_y !== 16'd12) begin errors++; $display("FAIL orphan_rsp_y: got %0d want 12", a_rsp_y); end
            end
        end
        a_force = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_v;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            rst = (c == 3);
            a_req_vld = (c <= 3) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
            a_req_x = {32'd49, 32'd16};
            #1;
            if (c == 3) begin
                checks++;
                if (a_req_rdy !== 2'b00 || a_x_vld !== 1'b0) begin
                    errors++; $display("FAIL midreset_rdy: rdy=%b xvld=%b want 00/0", a_req_rdy, a_x_vld);
                end
            end
            if (c == 4) begin
                checks++;
                if (a_req_rdy !== 2'b10 || a_x !== 32'd49) begin
                    errors++; $display("FAIL midreset_issue: rdy=%b x=%0d want 10/49", a_req_rdy, a_x);
                end
            end
            exp_v = (c == 10) ? 2'b10 : 2'b00;
            checks++;
            if (a_rsp_vld !== exp_v) begin
                errors++; $display("FAIL midreset_rsp_vld c=%0d: got %b want %b", c, a_rsp_vld, exp_v);
            end
            if (c == 10) begin
                checks++;
                if (a_rsp_y !== 16'd7) begin errors++; $display("FAIL midreset_rsp_y: got %0d want 7", a_rsp_y); end
            end
        end
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", a_err); end
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        errors = 0;
        checks = 0;
        a_req_vld = '0; a_req_x = '0; a_force = 1'b0;
        b_req_vld = '0; b_req_x = '0;
        test_reset();
        test_single();
        test_contention();
        test_full_fifo();
        test_rr_wrap();
        test_orphan();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
